axi_imem_slave: RTL

AXI_IMEM_SLAVE -- requirements
Module: axi_imem_slave

---
 rtl/axi_imem_slave_pkg.sv | 18 +
 rtl/axi_r_skid_buf.sv | 44 ++++
 rtl/axi_imem_slave.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/axi_imem_slave_pkg.sv
// Shared AXI encodings and slave state type for the instruction-memory AXI slave.
package axi_imem_slave_pkg;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } slave_state_t;

    // AXI size code for a beat of the given number of bytes
    function automatic logic [2:0] axsize_for(input int unsigned bytes);
        return 3'($clog2(bytes));
    endfunction

endpackage

// File: rtl/axi_r_skid_buf.sv
// Two-entry FIFO holding R-channel beats; head stays stable until popped.
module axi_r_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] slot0;
    logic [WIDTH-1:0] slot1;
    logic             rd_ptr;
    logic             wr_ptr;
    logic             pop;

    assign out_valid = (count != 2'd0);
    assign pop       = out_valid && out_ready;
    assign out_data  = rd_ptr ? slot1 : slot0;

    // Storage, pointers and occupancy; writer never pushes into a full buffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot0  <= '0;
            slot1  <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                if (wr_ptr) slot1 <= push_data;
                else        slot0 <= push_data;
                wr_ptr <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end

endmodule

// File: rtl/axi_imem_slave.sv
// AXI4 read-only slave fronting a synchronous instruction memory (one burst at a time).
module axi_imem_slave
    import axi_imem_slave_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 128,
    parameter logic [ADDR_WIDTH-1:0] MEM_BASE   = 'h1000,
    parameter int                    MEM_DEPTH  = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ADDR_WIDTH-1:0]        s_axi_araddr,
    input  logic [7:0]                   s_axi_arlen,
    input  logic [2:0]                   s_axi_arsize,
    input  logic [1:0]                   s_axi_arburst,
    input  logic [3:0]                   s_axi_arcache,
    input  logic [2:0]                   s_axi_arprot,
    input  logic [3:0]                   s_axi_arqos,
    input  logic [3:0]                   s_axi_arregion,
    input  logic                         s_axi_arvalid,
    output logic                         s_axi_arready,
    output logic [DATA_WIDTH-1:0]        s_axi_rdata,
    output logic [1:0]                   s_axi_rresp,
    output logic                         s_axi_rlast,
    output logic                         s_axi_rvalid,
    input  logic                         s_axi_rready,
    output logic                         mem_en,
    output logic [$clog2(MEM_DEPTH)-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0]        mem_rdata
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFF   = $clog2(BYTES);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int EW    = ADDR_WIDTH + 13;
    localparam int BUF_W = DATA_WIDTH + 3;
    localparam logic [EW-1:0] MEM_END = EW'(MEM_BASE) + (EW'(MEM_DEPTH) << OFF);

    slave_state_t     state;
    logic [8:0]       issue_cnt;
    logic [7:0]       len;
    logic             err;
    logic [IDX_W-1:0] base_idx;
    logic             inflight;
    logic             inflight_err;
    logic             inflight_last;

    logic [EW-1:0]         addr_ext;
    logic [EW-1:0]         last_beat_addr;
    logic [EW-1:0]         end_byte;
    logic                  ar_err;
    logic [IDX_W-1:0]      ar_index;
    logic                  issue;
    logic                  pop;
    logic                  buf_valid;
    logic [1:0]            buf_count;
    logic [BUF_W-1:0]      buf_data;
    logic [BUF_W-1:0]      buf_data_in;
    logic [DATA_WIDTH-1:0] beat_data;
    logic                  unused_ar_attrs;

    assign unused_ar_attrs = ^{s_axi_arcache, s_axi_arprot, s_axi_arqos, s_axi_arregion};

    // Burst legality: the 4 KB check compares the page of the first and last byte
    assign addr_ext       = EW'(s_axi_araddr);
    assign last_beat_addr = addr_ext + (EW'(s_axi_arlen) << OFF);
    assign end_byte       = last_beat_addr + EW'(BYTES - 1);
    assign ar_err = (s_axi_arburst != AXI_BURST_INCR)
                 || (s_axi_arsize != axsize_for(BYTES))
                 || (s_axi_araddr[OFF-1:0] != '0)
                 || (s_axi_araddr < MEM_BASE)
                 || (last_beat_addr >= MEM_END)
                 || ((addr_ext >> 12) != (end_byte >> 12));
    assign ar_index = IDX_W'((s_axi_araddr - MEM_BASE) >> OFF);

    assign s_axi_arready = (state == ST_IDLE) && !rst;

    // A beat may issue only if it will find room in the buffer when its data lands
    assign pop   = buf_valid && s_axi_rready;
    assign issue = (state == ST_BURST)
                && (issue_cnt <= {1'b0, len})
                && (({1'b0, buf_count} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));

    assign mem_en   = issue && !err;
    assign mem_addr = base_idx + IDX_W'(issue_cnt);

    assign beat_data   = inflight_err ? '0 : mem_rdata;
    assign buf_data_in = {beat_data, inflight_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY, inflight_last};

    // Burst control FSM plus the one-cycle memory-latency tracking stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            issue_cnt     <= '0;
            len           <= '0;
            err           <= 1'b0;
            base_idx      <= '0;
            inflight      <= 1'b0;
            inflight_err  <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (s_axi_arvalid) begin
                        len       <= s_axi_arlen;
                        err       <= ar_err;
                        base_idx  <= ar_index;
                        issue_cnt <= '0;
                        state     <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (issue) issue_cnt <= issue_cnt + 9'd1;
                    if (pop && s_axi_rlast) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
            inflight      <= issue;
            inflight_err  <= err;
            inflight_last <= (issue_cnt == {1'b0, len});
        end
    end

    axi_r_skid_buf #(
        .WIDTH(BUF_W)
    ) u_rbuf (
        .clk      (clk),
        .rst      (rst),
        .push     (inflight),
        .push_data(buf_data_in),
        .out_valid(buf_valid),
        .out_ready(s_axi_rready),
        .out_data (buf_data),
        .count    (buf_count)
    );

    assign s_axi_rvalid = buf_valid;
    assign s_axi_rdata  = buf_data[BUF_W-1:3];
    assign s_axi_rresp  = buf_data[2:1];
    assign s_axi_rlast  = buf_data[0];

endmodule
